// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: core has fixed priority, dbg has bounded wait (MAX_WAIT), read data routed to owner.
// Grant is combinational, read return 1 cycle. Optional DMEM_ARB_LOCK_EN holds dbg grant across beats.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_DBG} rd_owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  rd_owner_t   rd_owner_q, rd_owner_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        lock_q;
  logic        core_gnt;
  logic        dbg_sel;
  logic        dbg_gnt_int;

  always_comb begin
    core_gnt = 1'b0;
    dbg_sel  = 1'b0;
    if (lock_q)
      dbg_sel = 1'b1;
    else if (dbg_req && (wait_cnt_q == WAIT_MAX))
      dbg_sel = 1'b1;
    else if (core_req)
      core_gnt = 1'b1;
    else if (dbg_req)
      dbg_sel = 1'b1;
  end

  assign dbg_gnt_int = dbg_req & dbg_sel;

  // Combinational outputs are forced low for as long as reset is asserted.
  assign core_stall = reset & core_req & ~core_gnt;
  assign dbg_gnt    = reset & dbg_gnt_int;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (core_gnt) begin
        mem_en    = 1'b1;
        mem_we    = core_we;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end else if (dbg_gnt_int) begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (lock_q || dbg_gnt_int || !dbg_req)
      wait_cnt_d = 4'd0;
    else if (wait_cnt_q < WAIT_MAX)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_comb begin
    rd_owner_d = RD_NONE;
    if (core_gnt && !core_we)
      rd_owner_d = RD_CORE;
    else if (dbg_gnt_int && !dbg_we)
      rd_owner_d = RD_DBG;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_owner_q <= RD_NONE;
      wait_cnt_q <= 4'd0;
    end else begin
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  logic lock_d;

  // Once taken, the lock survives only while dbg keeps both req and lock high.
  assign lock_d = lock_q ? (dbg_req & dbg_lock) : (dbg_gnt_int & dbg_lock);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      lock_q <= 1'b0;
    else
      lock_q <= lock_d;
  end
`else
  logic unused_dbg_lock;

  assign unused_dbg_lock = dbg_lock;
  assign lock_q          = 1'b0;
`endif

  assign core_rvalid = (rd_owner_q == RD_CORE);
  assign dbg_rvalid  = (rd_owner_q == RD_DBG);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for grants/mem strobes, scoreboard queue for read returns.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [DW-1:0] core_wdata, dbg_wdata;
  logic          core_stall, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] core_rdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Single-port RAM with registered read.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  logic [DW-1:0] refm [0:255];

  typedef struct {
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          dreq, dwe, dlock;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic          x_stall, x_gnt, x_en, x_we;
    logic [AW-1:0] x_addr;
  } vec_t;

  typedef struct {
    logic [1:0]    owner;
    logic [DW-1:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic creq, cwe, input logic [AW-1:0] caddr,
                              input logic [DW-1:0] cwd, input logic dreq, dwe, dlock,
                              input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                              input logic xs, xg, xe, xw, input logic [AW-1:0] xa);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.dlock = dlock; v.daddr = daddr; v.dwd = dwd;
    v.x_stall = xs; v.x_gnt = xg; v.x_en = xe; v.x_we = xw; v.x_addr = xa;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_lock = v.dlock; dbg_addr = v.daddr; dbg_wdata = v.dwd;
  endtask

  task automatic apply(input int idx, input vec_t v);
    exp_t          e;
    logic [DW-1:0] wd;
    drive(v);
    #2;
    wd = v.x_en ? (v.x_gnt ? v.dwd : v.cwd) : '0;
    chk($sformatf("v%0d core_stall", idx), 32'(core_stall), 32'(v.x_stall));
    chk($sformatf("v%0d dbg_gnt", idx), 32'(dbg_gnt), 32'(v.x_gnt));
    chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(v.x_en));
    chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.x_we));
    chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.x_addr));
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, wd);
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.owner = 2'd0; e.data = '0; end
    chk($sformatf("v%0d core_rvalid", idx), 32'(core_rvalid), 32'(e.owner == 2'd1));
    chk($sformatf("v%0d core_rdata", idx), core_rdata, (e.owner == 2'd1) ? e.data : '0);
    chk($sformatf("v%0d dbg_rvalid", idx), 32'(dbg_rvalid), 32'(e.owner == 2'd2));
    chk($sformatf("v%0d dbg_rdata", idx), dbg_rdata, (e.owner == 2'd2) ? e.data : '0);
    if (v.x_en && !v.x_we) begin
      e.owner = v.x_gnt ? 2'd2 : 2'd1;
      e.data  = refm[v.x_addr];
    end else begin
      e.owner = 2'd0;
      e.data  = '0;
    end
    sb.push_back(e);
    if (v.x_en && v.x_we) refm[v.x_addr] = wd;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " core_stall"}, 32'(core_stall), 32'd0);
    chk({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'd0);
    chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'd0);
    chk({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
    chk({tag, " core_rdata"}, core_rdata, 32'd0);
    chk({tag, " dbg_rdata"}, dbg_rdata, 32'd0);
  endtask

  initial begin
    vec_t idle_v;
    for (int i = 0; i < 256; i++) begin
      ram[i]  = {24'hC0FFEE, 8'(i)};
      refm[i] = {24'hC0FFEE, 8'(i)};
    end
    idle_v = mk(0,0,8'h00,0, 0,0,0,8'h00,0, 0,0,0,0,8'h00);

    // Reset held with core_req and dbg_req active: every output stays low.
    drive(mk(1,0,8'h05,32'h11, 1,1,0,8'h06,32'h22, 0,0,0,0,8'h00));
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk_all_zero($sformatf("rst%0d", c));
    end
    reset = 1'b1;

    //            creq cwe caddr cwd           dreq dwe lk daddr dwd           stl gnt en we addr
    tbl.push_back(mk(1,0,8'h05,32'h0,          0,0,0,8'h00,32'h0,          0,0,1,0,8'h05));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,32'h0,          1,1,0,8'h10,32'hDEADBEEF,   0,1,1,1,8'h10));
    tbl.push_back(mk(1,0,8'h10,32'h0,          0,0,0,8'h00,32'h0,          0,0,1,0,8'h10));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));
    tbl.push_back(mk(1,0,8'h01,32'h0,          0,0,0,8'h00,32'h0,          0,0,1,0,8'h01));
    tbl.push_back(mk(0,0,8'h00,32'h0,          1,0,0,8'h02,32'h55,         0,1,1,0,8'h02));
    tbl.push_back(mk(1,0,8'h01,32'h0,          0,0,0,8'h00,32'h0,          0,0,1,0,8'h01));
    tbl.push_back(mk(0,0,8'h00,32'h0,          1,0,0,8'h02,32'h55,         0,1,1,0,8'h02));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));
    tbl.push_back(mk(1,1,8'h20,32'h12345678,   0,0,0,8'h00,32'h0,          0,0,1,1,8'h20));
    tbl.push_back(mk(0,0,8'h00,32'h0,          1,0,0,8'h20,32'h0,          0,1,1,0,8'h20));
    tbl.push_back(mk(1,0,8'hFF,32'h0,          0,0,0,8'h00,32'h0,          0,0,1,0,8'hFF));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));
    // Contention: four core wins, then the starved dbg request is forced through.
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,0,8'h03,32'h0,        1,0,0,8'h04,32'h77,         0,0,1,0,8'h03));
    tbl.push_back(mk(1,0,8'h03,32'h0,          1,0,0,8'h04,32'h77,         1,1,1,0,8'h04));
    tbl.push_back(mk(1,0,8'h03,32'h0,          1,0,0,8'h04,32'h77,         0,0,1,0,8'h03));
    tbl.push_back(mk(0,0,8'h00,32'h0,          1,0,0,8'h04,32'h77,         0,1,1,0,8'h04));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));

    foreach (tbl[i]) apply(i, tbl[i]);

    // Granted core read, then reset pulsed: the in-flight read must vanish.
    apply(100, mk(1,0,8'h07,32'h0, 0,0,0,8'h00,32'h0, 0,0,1,0,8'h07));
    drive(idle_v);
    reset = 1'b0;
    #1;
    chk_all_zero("rst_inflight");
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply(101, idle_v);
    apply(102, idle_v);

`ifdef DMEM_ARB_LOCK_EN
    tbl.delete();
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1,0,8'h03,32'h0,        1,1,1,8'h30,32'hA0,         0,0,1,0,8'h03));
    tbl.push_back(mk(1,0,8'h03,32'h0,          1,1,1,8'h30,32'hA0,         1,1,1,1,8'h30));
    tbl.push_back(mk(1,0,8'h03,32'h0,          1,1,1,8'h31,32'hA1,         1,1,1,1,8'h31));
    tbl.push_back(mk(1,0,8'h03,32'h0,          1,1,0,8'h32,32'hA2,         1,1,1,1,8'h32));
    tbl.push_back(mk(1,0,8'h31,32'h0,          0,0,0,8'h00,32'h0,          0,0,1,0,8'h31));
    tbl.push_back(mk(0,0,8'h00,32'h0,          0,0,0,8'h00,32'h0,          0,0,0,0,8'h00));
    foreach (tbl[i]) apply(200 + i, tbl[i]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
